// File: rtl/mcpu_core_cache_tlbfetch_arb_if.sv
// TLB page-table fetch handshake: request/reqaddr one way, stall/response the other.
// The requester side uses the master modport, the fetch-serving side uses slave.
interface mcpu_core_cache_tlbfetch_arb_if #(
  parameter int ADDR_W = 20,
  parameter int RESP_W = 32
);
  logic              request;
  logic [ADDR_W-1:0] reqaddr;
  logic              stall;
  logic [RESP_W-1:0] response;

  modport master (output request, output reqaddr, input stall, input response);
  modport slave  (input request, input reqaddr, output stall, output response);
endinterface

// File: rtl/mcpu_core_cache_tlbfetch_arb.sv
// Shares the single page-table fetcher between ITLB and DTLB, one fetch at a time.
// Optional macro MCPU_TLBARB_DPRIO_EN: DTLB wins simultaneous requests instead of round-robin.
module mcpu_core_cache_tlbfetch_arb #(
  parameter int ADDR_W    = 20,
  parameter int RESP_W    = 32,
  parameter int WD_CYCLES = 4096
) (
  input  logic                          clkrst_core_clk,
  input  logic                          clkrst_core_rst,
  mcpu_core_cache_tlbfetch_arb_if.slave  itlb,
  mcpu_core_cache_tlbfetch_arb_if.slave  dtlb,
  mcpu_core_cache_tlbfetch_arb_if.master fetch,
  output logic                          arb2core_wd_err
);

  localparam int WD_W = $clog2(WD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_q;
  logic              wd_err_q;
  logic              any_req;
  logic              owner_req;
  logic              pick;
  logic              in_fetch;
  logic [RESP_W-1:0] resp;

  assign any_req   = itlb.request | dtlb.request;
  assign owner_req = owner_q ? dtlb.request : itlb.request;
  assign in_fetch  = (state_q != ST_IDLE);
  assign resp      = fetch.response;

`ifdef MCPU_TLBARB_DPRIO_EN
  assign pick = dtlb.request;
`else
  logic rr_q;

  assign pick = (itlb.request & dtlb.request) ? rr_q : dtlb.request;

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      rr_q <= 1'b0;
    end else if (in_fetch && !fetch.stall) begin
      rr_q <= ~owner_q;
    end
  end
`endif

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A launched fetch always runs to completion; DRAIN only waits it out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (!fetch.stall)    state_d = ST_IDLE;
        else if (!owner_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!fetch.stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    itlb.stall    = itlb.request;
    dtlb.stall    = dtlb.request;
    fetch.request = in_fetch;
    fetch.reqaddr = addr_q;
    // Only a requesting owner in BUSY can be released; DRAIN keeps re-requests stalled.
    if (state_q == ST_BUSY) begin
      if (owner_q) dtlb.stall = dtlb.request & fetch.stall;
      else         itlb.stall = itlb.request & fetch.stall;
    end
  end

  assign itlb.response   = resp;
  assign dtlb.response   = resp;
  assign arb2core_wd_err = wd_err_q;

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && any_req) begin
        owner_q <= pick;
        addr_q  <= pick ? dtlb.reqaddr : itlb.reqaddr;
        wd_q    <= '0;
      end else if (in_fetch && wd_q != WD_W'(WD_CYCLES)) begin
        wd_q <= wd_q + 1'b1;
        if (wd_q == WD_W'(WD_CYCLES - 1)) wd_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_core_cache_tlbfetch_arb.sv
// Directed bench for the ITLB/DTLB fetch arbiter with hand-computed expectations.
module tb_mcpu_core_cache_tlbfetch_arb;

`ifdef MCPU_TLBARB_DPRIO_EN
  localparam bit FIRST_D = 1'b1;
`else
  localparam bit FIRST_D = 1'b0;
`endif

  logic clk;
  logic rst;
  logic wd_err;
  int   n_cmp;
  int   n_err;

  mcpu_core_cache_tlbfetch_arb_if #(.ADDR_W(20), .RESP_W(32)) itlb_if ();
  mcpu_core_cache_tlbfetch_arb_if #(.ADDR_W(20), .RESP_W(32)) dtlb_if ();
  mcpu_core_cache_tlbfetch_arb_if #(.ADDR_W(20), .RESP_W(32)) fetch_if ();

  mcpu_core_cache_tlbfetch_arb dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .itlb            (itlb_if),
    .dtlb            (dtlb_if),
    .fetch           (fetch_if),
    .arb2core_wd_err (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    chk("rst_fetch_req", fetch_if.request, 1'b0);
    chk("rst_wd_err", wd_err, 1'b0);
    tick();
    rst = 1'b0;
    settle();
  endtask

  logic [19:0] exp_addr;
  logic        own;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    itlb_if.request = 1'b0; itlb_if.reqaddr = '0;
    dtlb_if.request = 1'b0; dtlb_if.reqaddr = '0;
    fetch_if.stall = 1'b1;  fetch_if.response = '0;
    #12;

    // reset state: stalls follow requests, no fetch, no error
    chk("rst_fetch_req", fetch_if.request, 1'b0);
    chk("rst_fetch_addr", fetch_if.reqaddr, 20'h0);
    chk("rst_wd_err", wd_err, 1'b0);
    itlb_if.request = 1'b1;
    settle();
    chk("rst_itlb_stall_track", itlb_if.stall, 1'b1);
    chk("rst_fetch_req_held", fetch_if.request, 1'b0);
    itlb_if.request = 1'b0;
    settle();
    chk("rst_itlb_stall_low", itlb_if.stall, 1'b0);
    tick();
    rst = 1'b0;
    settle();

    // single ITLB fetch, VPN 0x12345, released in 6th BUSY cycle
    itlb_if.request = 1'b1; itlb_if.reqaddr = 20'h12345;
    settle();
    chk("t1_idle_fetch_req", fetch_if.request, 1'b0);
    chk("t1_idle_stall", itlb_if.stall, 1'b1);
    tick();
    itlb_if.reqaddr = 20'h55555;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("t1_busy_fetch_req", fetch_if.request, 1'b1);
      chk("t1_busy_addr", fetch_if.reqaddr, 20'h12345);
      chk("t1_busy_stall", itlb_if.stall, 1'b1);
      tick();
    end
    fetch_if.stall = 1'b0; fetch_if.response = 32'hABCDE00F;
    settle();
    chk("t1_rel_stall", itlb_if.stall, 1'b0);
    chk("t1_rel_resp", itlb_if.response, 32'hABCDE00F);
    chk("t1_bcast_resp", dtlb_if.response, 32'hABCDE00F);
    tick();
    itlb_if.request = 1'b0; fetch_if.stall = 1'b1;
    settle();
    chk("t1_back_idle", fetch_if.request, 1'b0);

    // simultaneous requests after reset
    do_reset();
    itlb_if.request = 1'b1; itlb_if.reqaddr = 20'h11111;
    dtlb_if.request = 1'b1; dtlb_if.reqaddr = 20'h22222;
    settle();
    chk("t2_idle_istall", itlb_if.stall, 1'b1);
    chk("t2_idle_dstall", dtlb_if.stall, 1'b1);
    tick();
    chk("t2_first_addr", fetch_if.reqaddr, FIRST_D ? 20'h22222 : 20'h11111);
    chk("t2_first_istall", itlb_if.stall, 1'b1);
    chk("t2_first_dstall", dtlb_if.stall, 1'b1);
    tick();
    fetch_if.stall = 1'b0;
    settle();
    chk("t2_first_rel", FIRST_D ? dtlb_if.stall : itlb_if.stall, 1'b0);
    chk("t2_wait_stall", FIRST_D ? itlb_if.stall : dtlb_if.stall, 1'b1);
    tick();
    if (FIRST_D) dtlb_if.request = 1'b0; else itlb_if.request = 1'b0;
    fetch_if.stall = 1'b1;
    settle();
    chk("t2_gap_fetch_req", fetch_if.request, 1'b0);
    chk("t2_gap_wait_stall", FIRST_D ? itlb_if.stall : dtlb_if.stall, 1'b1);
    tick();
    chk("t2_second_req", fetch_if.request, 1'b1);
    chk("t2_second_addr", fetch_if.reqaddr, FIRST_D ? 20'h11111 : 20'h22222);
    fetch_if.stall = 1'b0;
    settle();
    chk("t2_second_rel", FIRST_D ? itlb_if.stall : dtlb_if.stall, 1'b0);
    tick();
    itlb_if.request = 1'b0; dtlb_if.request = 1'b0; fetch_if.stall = 1'b1;
    settle();

    // both held over four fetches
    itlb_if.request = 1'b1; dtlb_if.request = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      own = FIRST_D ? 1'b1 : ((k % 2) == 1);
      exp_addr = own ? 20'h22222 : 20'h11111;
      chk("t3_idle_gap", fetch_if.request, 1'b0);
      tick();
      chk("t3_busy_req", fetch_if.request, 1'b1);
      chk("t3_grant_addr", fetch_if.reqaddr, exp_addr);
      fetch_if.stall = 1'b0;
      settle();
      chk("t3_owner_rel", own ? dtlb_if.stall : itlb_if.stall, 1'b0);
      chk("t3_other_stall", own ? itlb_if.stall : dtlb_if.stall, 1'b1);
      tick();
      fetch_if.stall = 1'b1;
      settle();
    end
    itlb_if.request = 1'b0; dtlb_if.request = 1'b0;
    settle();

    // DTLB withdraws mid-fetch -> drain, then pending ITLB
    dtlb_if.request = 1'b1; dtlb_if.reqaddr = 20'h0ABCD;
    settle();
    tick();
    itlb_if.request = 1'b1; itlb_if.reqaddr = 20'h33333;
    settle();
    chk("t4_busy_addr", fetch_if.reqaddr, 20'h0ABCD);
    chk("t4_istall", itlb_if.stall, 1'b1);
    chk("t4_dstall", dtlb_if.stall, 1'b1);
    tick();
    tick();
    dtlb_if.request = 1'b0;
    settle();
    chk("t4_drop_req", fetch_if.request, 1'b1);
    chk("t4_drop_addr", fetch_if.reqaddr, 20'h0ABCD);
    chk("t4_drop_istall", itlb_if.stall, 1'b1);
    tick();
    dtlb_if.request = 1'b1;
    settle();
    chk("t4_drain_rereq_stall", dtlb_if.stall, 1'b1);
    chk("t4_drain_req", fetch_if.request, 1'b1);
    chk("t4_drain_addr", fetch_if.reqaddr, 20'h0ABCD);
    tick();
    fetch_if.stall = 1'b0;
    settle();
    chk("t4_drain_done_dstall", dtlb_if.stall, 1'b1);
    chk("t4_drain_done_istall", itlb_if.stall, 1'b1);
    tick();
    fetch_if.stall = 1'b1;
    settle();
    chk("t4_idle_gap", fetch_if.request, 1'b0);
    tick();
    chk("t4_regrant_addr", fetch_if.reqaddr, FIRST_D ? 20'h0ABCD : 20'h33333);
    fetch_if.stall = 1'b0;
    settle();
    chk("t4_regrant_rel", FIRST_D ? dtlb_if.stall : itlb_if.stall, 1'b0);
    tick();
    itlb_if.request = 1'b0; dtlb_if.request = 1'b0; fetch_if.stall = 1'b1;
    settle();

    // watchdog: fetch stalled past WD_CYCLES
    do_reset();
    itlb_if.request = 1'b1; itlb_if.reqaddr = 20'h00001;
    settle();
    tick();
    repeat (4095) tick();
    chk("t5_wd_before", wd_err, 1'b0);
    chk("t5_still_fetching", fetch_if.request, 1'b1);
    tick();
    chk("t5_wd_rise", wd_err, 1'b1);
    repeat (10) tick();
    chk("t5_wd_sat", wd_err, 1'b1);
    fetch_if.stall = 1'b0;
    settle();
    chk("t5_late_rel", itlb_if.stall, 1'b0);
    tick();
    itlb_if.request = 1'b0; fetch_if.stall = 1'b1;
    settle();
    chk("t5_wd_sticky", wd_err, 1'b1);
    do_reset();
    chk("t5_wd_cleared", wd_err, 1'b0);

    // reset in the middle of a BUSY fetch
    itlb_if.request = 1'b1; itlb_if.reqaddr = 20'h44444;
    settle();
    tick();
    chk("t6_busy", fetch_if.request, 1'b1);
    #2;
    rst = 1'b1;
    settle();
    chk("t6_rst_fetch_req", fetch_if.request, 1'b0);
    chk("t6_rst_istall", itlb_if.stall, 1'b1);
    dtlb_if.request = 1'b1;
    settle();
    chk("t6_rst_dstall", dtlb_if.stall, 1'b1);
    tick();
    chk("t6_rst_hold", fetch_if.request, 1'b0);
    itlb_if.request = 1'b0; dtlb_if.request = 1'b0;
    rst = 1'b0;
    settle();
    chk("t6_after_idle", fetch_if.request, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
